hazard_ctrl: RTL
================

# hazard_ctrl

Central pipeline sequencer for the five-stage MIPS core. Each cycle it computes the enable and flush controls for the PC and the four pipeline registers (IF/ID, ID/EX, EX/ME, ME/WB). It covers three cases: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses with a bounded timeout. A two-state FSM plus a wait counter hold the whole pipeline while memory is busy; all other decisions are single-cycle.

## Interface
- MEM_TIMEOUT, 15: maximum cycles spent in MEM_WAIT before forced release; must be ≥1.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- ex_rt  in  5  destination rt of the instruction in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- me_mem_req  in  1  instruction in ME accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC load enable.
- if_id_en, id_ex_en, ex_me_en, me_wb_en  out  1 each  register load enables.
- if_id_flush, id_ex_flush  out  1 each  load a bubble (all zero) instead of data.
- me_wb_bubble  out  1  force Ctrl_regWr/Ctrl_Mem2Reg to 0 in the ME/WB load.
- mem_err  out  1  one-cycle pulse on memory timeout.
- busy  out  1  FSM is in MEM_WAIT.

## Operation
- States: RUN, MEM_WAIT. Wait counter width is $clog2(MEM_TIMEOUT+1).
- Defaults in RUN: all enables 1; flushes, bubble, mem_err and busy 0.
- mem_stall = (RUN & me_mem_req & !mem_ready) | (MEM_WAIT & !mem_ready & cnt != MEM_TIMEOUT).
- Priority 1, mem_stall:
  - pc_en, if_id_en, id_ex_en and ex_me_en are 0.
  - me_wb_en is 1 and me_wb_bubble is 1.
  - All other conditions are ignored.
- Priority 2, ex_branch_taken:
  - if_id_flush and id_ex_flush are 1; pc_en is 1.
  - Load-use detection is suppressed.
- Priority 3, load-use hit = ex_mem_read & ex_rt != 0 & (ex_rt == id_rs | ex_rt == id_rt):
  - pc_en and if_id_en are 0; id_ex_flush is 1.
  - Lasts exactly one cycle; no state is involved.
- Transition RUN→MEM_WAIT when me_mem_req & !mem_ready; the counter loads 1.
- In MEM_WAIT, the counter increments each cycle.
- MEM_WAIT→RUN when mem_ready, or when cnt == MEM_TIMEOUT.
  - mem_ready wins if both hold; that exit cycle uses the RUN defaults.
  - On a timeout exit, mem_err=1 for that cycle. The stalled access completes with undefined load data, and the pipeline advances.
- A request with mem_ready in the same cycle in RUN never stalls.
- A branch or load-use present during MEM_WAIT stays held in EX/ID. It is re-evaluated on the release cycle.

## Timing
- All outputs are combinational functions of the registered state/counter and the current inputs (Mealy). There is no added latency: a hazard visible in cycle N controls the register loads at the end of cycle N.
- While rst=1, in the same cycle:
  - All enables are 1, if_id_flush=id_ex_flush=me_wb_bubble=1, mem_err=0, busy=0.
  - Every pipeline register therefore captures a bubble on the reset edge.
- After reset: state RUN, counter 0, and the perf counter (if present) 0.
- rst asserted during MEM_WAIT returns to RUN on the next edge with no mem_err pulse.
- Load-use plus mem_stall: the stall covers it. After release, the load-use bubble still occurs if the hit persists.
- MEM_TIMEOUT=1: the wait lasts exactly one cycle in MEM_WAIT.

## Configuration
- HAZARD_CTRL_PERF_EN defined:
  - Adds output stall_cycles [31:0], a saturating count of cycles with pc_en=0.
  - Adds output flush_count [31:0], a saturating count of cycles with if_id_flush=1 outside reset.
  - Both clear on rst.
- HAZARD_CTRL_PERF_EN undefined: both ports and their registers are absent; all other behaviour is identical.

## Structure
- Shared package hazard_pkg holds the state encodings (RUN=1'b0, MEM_WAIT=1'b1) and the bubble constant for pipeline-register width zeros.
- One sub-module, hazard_detect: the purely combinational load-use compare. It takes id_rs, id_rt, ex_rt and ex_mem_read and outputs hit.
- The FSM, counter, priority mux and perf counters live in hazard_ctrl.

## Test plan
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 → for one cycle pc_en=0, if_id_en=0, id_ex_flush=1. Repeat with ex_rt=0 → no stall.
- Branch over load-use: ex_branch_taken=1 plus a load-use hit → if_id_flush=id_ex_flush=1 and pc_en=1.
- Memory wait: me_mem_req=1, mem_ready low for 3 cycles, then high → busy for 3 cycles, stage enables 0, me_wb_bubble=1, RUN on the 4th cycle, mem_err never set.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → after 4 cycles in MEM_WAIT, mem_err pulses once and enables return to 1.
- Reset mid-wait: rst during MEM_WAIT → next cycle RUN, counter 0, all flushes observed during rst, no mem_err.
- Perf (HAZARD_CTRL_PERF_EN): a 3-cycle memory stall plus one load-use stall → stall_cycles=4; one branch → flush_count=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/pipeline sequencer: FSM states and the
// all-zero bubble value loaded into a flushed pipeline register.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int                    PIPE_REG_W = 64;
  localparam logic [PIPE_REG_W-1:0] BUBBLE     = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use compare: the load in EX writes a register the instruction in ID reads.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] ex_rt,
  input  logic       ex_mem_read,
  output logic       hit
);

  // $zero never creates a dependency, so ex_rt == 0 is excluded.
  always_comb begin
    hit = ex_mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline enable/flush sequencer for the five-stage core (Mealy outputs).
// Optional perf counters stall_cycles/flush_count under `HAZARD_CTRL_PERF_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] ex_rt,
  input  logic       ex_mem_read,
  input  logic       ex_branch_taken,
  input  logic       me_mem_req,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_me_en,
  output logic       me_wb_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       me_wb_bubble,
  output logic       mem_err,
  output logic       busy
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  localparam int               CNT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use_hit;
  logic             mem_stall;
  logic             timeout;

  hazard_detect u_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_rt       (ex_rt),
    .ex_mem_read (ex_mem_read),
    .hit         (load_use_hit)
  );

  always_comb begin
    mem_stall = ((state_q == RUN) && me_mem_req && !mem_ready) ||
                ((state_q == MEM_WAIT) && !mem_ready && (cnt_q != CNT_MAX));
    timeout   = (state_q == MEM_WAIT) && !mem_ready && (cnt_q == CNT_MAX);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (me_mem_req && !mem_ready) begin
          state_d = MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready || (cnt_q == CNT_MAX)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Priority: reset bubble, then memory stall, branch flush, load-use bubble.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_me_en     = 1'b1;
    me_wb_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    me_wb_bubble = 1'b0;
    mem_err      = 1'b0;
    busy         = 1'b0;
    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      me_wb_bubble = 1'b1;
    end else begin
      busy    = (state_q == MEM_WAIT);
      mem_err = timeout;
      if (mem_stall) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_me_en     = 1'b0;
        me_wb_bubble = 1'b1;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use_hit) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!pc_en && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (if_id_flush && (flush_count_q != 32'hFFFF_FFFF)) begin
      flush_count_d = flush_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule
